// File: rtl/ppu_sprite_pkg.sv
// Shared constants for the sprite pixel generator: slot count, load_in field
// positions and load strobe indices.
package ppu_sprite_pkg;
  localparam int NUM_SLOTS = 8;
  localparam int LOAD_W    = 27;

  localparam int PIX1_LSB = 19;
  localparam int PIX2_LSB = 11;
  localparam int X_LSB    = 3;
  localparam int PAL_LSB  = 1;
  localparam int PRI_BIT  = 0;

  localparam int LD_ATTR = 0;
  localparam int LD_X    = 1;
  localparam int LD_PIX2 = 2;
  localparam int LD_PIX1 = 3;
endpackage

// File: rtl/sprite_slot.sv
// One sprite slot: attributes, x countdown and two 8-bit pattern shifters.
// Strobes arrive already gated by clock enable and slot select.
module sprite_slot (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift,
  input  logic [3:0]  load,
  input  logic [26:0] load_in,
  output logic [1:0]  color,
  output logic [1:0]  pal,
  output logic        prio
);
  import ppu_sprite_pkg::*;

  logic [7:0] x, plane0, plane1;
  logic       active;

  assign active = (x == 8'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      x      <= '0;
      plane0 <= '0;
      plane1 <= '0;
      pal    <= '0;
      prio   <= 1'b0;
    end else begin
      if (load[LD_ATTR]) begin
        pal  <= load_in[PAL_LSB +: 2];
        prio <= load_in[PRI_BIT];
      end
      if (load[LD_X])       x <= load_in[X_LSB +: 8];
      else if (shift && !active) x <= x - 8'd1;
      // A written plane wins over both the line clear and the shift.
      if (load[LD_PIX1])    plane0 <= load_in[PIX1_LSB +: 8];
      else if (clear)       plane0 <= '0;
      else if (shift && active) plane0 <= plane0 >> 1;
      if (load[LD_PIX2])    plane1 <= load_in[PIX2_LSB +: 8];
      else if (clear)       plane1 <= '0;
      else if (shift && active) plane1 <= plane1 >> 1;
    end
  end

  assign color = active ? {plane1[0], plane0[0]} : 2'b00;
endmodule

// File: rtl/sprite_pixel_gen.sv
// Per-scanline sprite pixel generator: slot loading, per-slot shifters and a
// lowest-index-wins priority chain feeding a registered pixel output.
module sprite_pixel_gen #(
  parameter int NUM_SLOTS = ppu_sprite_pkg::NUM_SLOTS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic        enabled,
  input  logic        fetch_start,
  input  logic        sprite0_in_range,
  input  logic [3:0]  load,
  input  logic [26:0] load_in,
  input  logic        shift_en,
  output logic [4:0]  spr_pixel,
  output logic        spr_is_zero
);
  import ppu_sprite_pkg::*;

  localparam int PTR_W = $clog2(NUM_SLOTS + 1);

  logic [PTR_W-1:0] ptr, idx;
  logic             hit, shift, clear, s0;
  logic [4:0]       pix_q, win_pix;
  logic             zero_q, win_zero;

  logic [NUM_SLOTS-1:0][1:0] color, pal;
  logic [NUM_SLOTS-1:0]      prio;

  // fetch_start redirects a coincident load to slot 0.
  assign idx   = fetch_start ? '0 : ptr;
  assign hit   = (idx < PTR_W'(NUM_SLOTS));
  assign shift = ce & shift_en;
  assign clear = ce & fetch_start;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
      s0  <= 1'b0;
    end else if (ce) begin
      if (fetch_start) begin
        s0  <= sprite0_in_range;
        ptr <= load[LD_PIX2] ? PTR_W'(1) : '0;
      end else if (load[LD_PIX2] && hit) begin
        ptr <= ptr + PTR_W'(1);
      end
    end
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    logic [3:0] slot_load;
    assign slot_load = (ce && hit && idx == PTR_W'(g)) ? load : 4'b0000;

    sprite_slot u_slot (
      .clk     (clk),
      .reset   (reset),
      .clear   (clear),
      .shift   (shift),
      .load    (slot_load),
      .load_in (load_in),
      .color   (color[g]),
      .pal     (pal[g]),
      .prio    (prio[g])
    );
  end

  // Walk from the highest slot down so the lowest opaque slot is written last.
  always_comb begin
    win_pix  = '0;
    win_zero = 1'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (color[i] != 2'b00) begin
        win_pix  = {prio[i], pal[i], color[i]};
        win_zero = (i == 0) && s0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pix_q  <= '0;
      zero_q <= 1'b0;
    end else if (shift) begin
      pix_q  <= win_pix;
      zero_q <= win_zero;
    end
  end

  assign spr_pixel   = enabled ? pix_q : 5'd0;
  assign spr_is_zero = enabled & zero_q;
endmodule

// File: doc/sprite_pixel_gen.md
SPRITE_PIXEL_GEN -- requirements
Module: sprite_pixel_gen

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 8, meaning the number of sprite slots held per scanline.
REQ-002 SHALL have port clk  input  1  system clock; the block has one clock, and all state updates on the rising edge of clk.
REQ-003 SHALL have port reset  input  1  reset; reset is synchronous and active-high.
REQ-004 SHALL have port ce  input  1  clock enable; state SHALL change only when ce=1 (reset excepted).
REQ-005 SHALL have port enabled  input  1  sprite rendering enable; when 0, spr_pixel and spr_is_zero output 0.
REQ-006 SHALL have port fetch_start  input  1  pulse at start of sprite fetch phase; resets the slot pointer.
REQ-007 SHALL have port sprite0_in_range  input  1  sprite 0 occupies slot 0 for the next line; sampled on fetch_start.
REQ-008 SHALL have port load  input  4  field strobes {pix1, pix2, x, attr} = bits [3:0] from the address generator.
REQ-009 SHALL have port load_in  input  27  field data: [26:19] pix1, [18:11] pix2, [10:3] x, [2:1] palette, [0] priority.
REQ-010 SHALL have port shift_en  input  1  visible-pixel cycle; x counters and shifters advance.
REQ-011 SHALL have port spr_pixel  output  5  {priority, palette[1:0], color[1:0]} of the winning sprite pixel.
REQ-012 SHALL have port spr_is_zero  output  1  winning opaque pixel came from sprite 0.

Function
REQ-013 Slot pointer SHALL clear to 0 on fetch_start, and SHALL increment after each cycle with ce & load[2] (pix2 is the last field per slot).
REQ-014 Pointer SHALL saturate at NUM_SLOTS; loads with pointer = NUM_SLOTS SHALL be ignored.
REQ-015 load[0] SHALL write palette/priority; load[1] SHALL write the x counter; load[3] SHALL write plane 0; load[2] SHALL write plane 1, each into the slot at the pointer.
REQ-016 Plane bytes arrive pre-flipped; the shifter SHALL output bit 0 first and shift right, filling with 0.
REQ-017 On each ce & shift_en cycle, a slot with x != 0 SHALL decrement x; a slot with x = 0 SHALL shift both planes one bit.
REQ-018 Slot color SHALL be {plane1[0], plane0[0]} when x = 0, else 2'b00.
REQ-019 The winner SHALL be the lowest-index slot with nonzero color; if none, the color SHALL be 0.
REQ-020 Registered outputs SHALL update one ce-cycle after shift_en; latency from the shifter state to spr_pixel SHALL be 1 clock.
REQ-021 spr_is_zero SHALL be 1 only if the winner is slot 0, the sprite-0 flag is latched, and the color is nonzero.
REQ-022 When shift_en=0, outputs SHALL hold their last values, except that enabled=0 forces 0.
REQ-023 A load and shift_en in the same cycle SHALL give priority to the load for the written field; the slot's other fields SHALL still advance.
REQ-024 fetch_start together with load SHALL apply the load to slot 0 and set the pointer as if slot 0 were loaded.
REQ-025 Unloaded slots SHALL retain zero planes and be transparent, because planes clear on fetch_start.

Reset
REQ-026 Reset SHALL clear the pointer, the sprite-0 flag, all planes, x counters, attributes, spr_pixel and spr_is_zero to 0, regardless of ce.
REQ-027 Reset during fetch or shift SHALL abort the operation; the next cycle SHALL behave as after power-up.

Structure
REQ-028 Package ppu_sprite_pkg SHALL hold NUM_SLOTS, the load_in field bit positions, and the load strobe indices.
REQ-029 One sub-module, sprite_slot (holds attributes, x counter and two 8-bit shifters; outputs a 2-bit color plus attributes), SHALL be instantiated NUM_SLOTS times.
REQ-030 The winner mux SHALL be a priority chain in the top level.

Verification
REQ-031 Load slot 0 with pix1=0x01, pix2=0x00, x=3, pal=2, pri=0, then shift -> spr_pixel=5'b01001 exactly 4 clocks after the first shift_en (x=3 decrements plus 1-clock output latency), then 0.
REQ-032 Load slots 0 and 1 at x=0: slot 0 planes 0x00/0x00, slot 1 planes 0xFF/0xFF with pal=1 -> output color 3, pal 1 (slot 0 transparent).
REQ-033 Load both slots opaque at x=0 with sprite0_in_range=1 -> winner is slot 0 and spr_is_zero=1; with sprite0_in_range=0, spr_is_zero=0.
REQ-034 Issue 9 full slot loads -> the ninth is ignored, the pointer holds 8, and the output matches the 8-slot result.
REQ-035 Assert reset mid-shift with ce=0 -> all outputs are 0 next clock and no residual pixels appear after reset.
REQ-036 enabled=0 with an opaque slot -> spr_pixel=0 and spr_is_zero=0; restoring enabled shows the pixel again.
